// File: rtl/keypad_matrix_model.sv
// 4x4 keypad switch-matrix emulator: replays one queued key press at a time, with
// deterministic LFSR contact bounce on press and release, and drives active-low rows.
module keypad_matrix_model #(
  parameter int          BOUNCE_CYCLES = 8,
  parameter int          GAP_CYCLES    = 4,
  parameter int          HOLD_W        = 16,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic [3:0]        col,
  output logic [3:0]        row,
  output logic              contact,
  output logic              done,
  output logic [2:0]        state_view
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    HOLD       = 3'd2,
    BOUNCE_OUT = 3'd3,
    GAP        = 3'd4
  } state_t;

  localparam int PAR_MAX = (BOUNCE_CYCLES > GAP_CYCLES) ? BOUNCE_CYCLES : GAP_CYCLES;
  localparam int PAR_W   = $clog2(PAR_MAX + 1);
  localparam int CNT_W   = (HOLD_W > PAR_W) ? HOLD_W : PAR_W;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        lfsr;
  logic [7:0]        lfsr_next;
  logic [3:0]        key_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_eff;

  // x^8+x^6+x^5+x^4+1, shifting left
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign hold_eff  = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;

  assign cmd_ready  = (state == IDLE);
  assign state_view = state;

  // NOTE: row gets a full default before the conditional override, so no latch is inferred.
  always_comb begin
    row = 4'b1111;
    if (contact && !col[key_q[1:0]])
      row[key_q[3:2]] = 1'b0;
  end

  // contact is loaded on the edge that enters a state, so it holds that state's value
  // for every cycle spent there; the LFSR only steps while a bounce cycle is being produced.
  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      lfsr    <= LFSR_SEED;
      key_q   <= '0;
      hold_q  <= '0;
      contact <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            key_q   <= cmd_key;
            hold_q  <= hold_eff;
            cnt     <= BOUNCE_LOAD;
            contact <= lfsr[0];
            lfsr    <= lfsr_next;
            state   <= BOUNCE_IN;
          end
        end
        BOUNCE_IN: begin
          if (cnt == '0) begin
            cnt     <= CNT_W'(hold_q) - CNT_ONE;
            contact <= 1'b1;
            state   <= HOLD;
          end else begin
            cnt     <= cnt - CNT_ONE;
            contact <= lfsr[0];
            lfsr    <= lfsr_next;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt     <= BOUNCE_LOAD;
            contact <= lfsr[0];
            lfsr    <= lfsr_next;
            state   <= BOUNCE_OUT;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        BOUNCE_OUT: begin
          if (cnt == '0) begin
            cnt     <= GAP_LOAD;
            contact <= 1'b0;
            state   <= GAP;
          end else begin
            cnt     <= cnt - CNT_ONE;
            contact <= lfsr[0];
            lfsr    <= lfsr_next;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          contact <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_model.sv
// Directed bench for keypad_matrix_model: reset, row decoding, bounce trace,
// back-to-back handshake and asynchronous reset mid-press.
module tb_keypad_matrix_model;

  localparam int B = 8;
  localparam int G = 4;

  logic        CLK;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_key;
  logic [15:0] cmd_hold;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        contact;
  logic        done;
  logic [2:0]  state_view;

  int n_checks = 0;
  int n_errors = 0;

  keypad_matrix_model #(
    .BOUNCE_CYCLES(B),
    .GAP_CYCLES   (G),
    .HOLD_W       (16),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_key   (cmd_key),
    .cmd_hold  (cmd_hold),
    .col       (col),
    .row       (row),
    .contact   (contact),
    .done      (done),
    .state_view(state_view)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] key;
    logic [3:0] col;
    logic [3:0] exp_row;
  } row_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected state k negedges after the transfer edge, for an effective hold h.
  function automatic logic [2:0] exp_state(input int k, input int h);
    if (k >= 1 && k <= B)                       return 3'd1;
    else if (k > B && k <= B + h)               return 3'd2;
    else if (k > B + h && k <= 2 * B + h)       return 3'd3;
    else if (k > 2 * B + h && k <= 2 * B + h + G) return 3'd4;
    else                                        return 3'd0;
  endfunction

  task automatic press(input logic [3:0] key, input logic [15:0] hold);
    cmd_valid = 1'b1;
    cmd_key   = key;
    cmd_hold  = hold;
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_state(input string name, input logic [2:0] s, input int max_cycles);
    int n = 0;
    while (state_view !== s && n < max_cycles) begin
      @(negedge CLK);
      n++;
    end
    check(name, state_view, s);
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    int n = 0;
    while (done !== 1'b1 && n < max_cycles) begin
      @(negedge CLK);
      n++;
    end
    check(name, done, 1'b1);
  endtask

  row_vec_t   vecs[10];
  logic [7:0] in_trace;
  logic [7:0] out_trace;
  logic [2:0] es;
  logic       ec;

  initial begin
    // Bit i = contact during the i-th bounce cycle, from LFSR seed 8'hA5.
    in_trace  = 8'b1110_0101;
    out_trace = 8'b0110_1110;

    vecs[0] = '{4'h6, 4'b1011, 4'b1101};
    vecs[1] = '{4'h6, 4'b1110, 4'b1111};
    vecs[2] = '{4'h6, 4'b1101, 4'b1111};
    vecs[3] = '{4'h6, 4'b0111, 4'b1111};
    vecs[4] = '{4'h0, 4'b1110, 4'b1110};
    vecs[5] = '{4'hF, 4'b0111, 4'b0111};
    vecs[6] = '{4'h9, 4'b1101, 4'b1011};
    vecs[7] = '{4'h9, 4'b0000, 4'b1011};
    vecs[8] = '{4'hC, 4'b1111, 4'b1111};
    vecs[9] = '{4'h3, 4'b0110, 4'b1110};

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_key   = 4'h0;
    cmd_hold  = 16'd0;
    col       = 4'b0000;

    // Reset state
    #3;
    check("reset_row", row, 4'b1111);
    check("reset_ready", cmd_ready, 1'b1);
    check("reset_state", state_view, 3'd0);
    check("reset_contact", contact, 1'b0);
    check("reset_done", done, 1'b0);
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);

    // First press after reset: full cycle-by-cycle walk, key 6, hold 20, col 1011
    col = 4'b1011;
    press(4'h6, 16'd20);
    for (int k = 1; k <= 42; k++) begin
      es = exp_state(k, 20);
      case (es)
        3'd1:    ec = in_trace[k - 1];
        3'd2:    ec = 1'b1;
        3'd3:    ec = out_trace[k - 1 - B - 20];
        default: ec = 1'b0;
      endcase
      check($sformatf("walk_state_k%0d", k), state_view, es);
      check($sformatf("walk_contact_k%0d", k), contact, ec);
      check($sformatf("walk_row_k%0d", k), row, ec ? 4'b1101 : 4'b1111);
      check($sformatf("walk_done_k%0d", k), done, (k == 41) ? 1'b1 : 1'b0);
      check($sformatf("walk_ready_k%0d", k), cmd_ready, (es == 3'd0) ? 1'b1 : 1'b0);
      @(negedge CLK);
    end

    // Row decoding table, one short press per vector
    for (int i = 0; i < 10; i++) begin
      col = 4'b1111;
      press(vecs[i].key, 16'd3);
      wait_state($sformatf("tbl%0d_reach_hold", i), 3'd2, 20);
      col = vecs[i].col;
      #1;
      check($sformatf("tbl%0d_row_key%0h_col%0b", i, vecs[i].key, vecs[i].col), row, vecs[i].exp_row);
      wait_done($sformatf("tbl%0d_done", i), 40);
    end

    // Back-to-back: valid stays high; hold=0 acts as 1; second command waits for IDLE
    col       = 4'b1101;
    cmd_valid = 1'b1;
    cmd_key   = 4'h9;
    cmd_hold  = 16'd0;
    @(negedge CLK);
    cmd_key  = 4'hF;
    cmd_hold = 16'd5;
    for (int k = 1; k <= 22; k++) begin
      check($sformatf("b2b_state_k%0d", k), state_view, exp_state(k, 1));
      if (k == B + 1)
        check("b2b_first_key_row", row, 4'b1011);
      check($sformatf("b2b_done_k%0d", k), done, (k == 22) ? 1'b1 : 1'b0);
      @(negedge CLK);
    end
    check("b2b_second_started", state_view, 3'd1);
    cmd_valid = 1'b0;
    col       = 4'b0111;
    wait_state("b2b_second_hold", 3'd2, 20);
    #1;
    check("b2b_second_key_row", row, 4'b0111);
    wait_done("b2b_second_done", 40);

    // Asynchronous reset mid-HOLD
    col = 4'b1011;
    press(4'h6, 16'd20);
    wait_state("arst_reach_hold", 3'd2, 20);
    @(negedge CLK);
    check("arst_row_before", row, 4'b1101);
    #2;
    rst = 1'b0;
    #1;
    check("arst_row", row, 4'b1111);
    check("arst_contact", contact, 1'b0);
    check("arst_state", state_view, 3'd0);
    check("arst_ready", cmd_ready, 1'b1);
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    col = 4'b1110;
    press(4'h0, 16'd1);
    check("arst_new_accept", state_view, 3'd1);
    wait_state("arst_new_hold", 3'd2, 20);
    check("arst_new_row", row, 4'b1110);
    wait_done("arst_new_done", 40);
    @(negedge CLK);
    check("arst_done_pulse_end", done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
